// File: rtl/display_pkg.sv
// Shared types and constants for the display scan controller.
package display_pkg;

    localparam int unsigned CODE_W = 5;

    typedef enum logic [1:0] {
        IDLE,
        BLANK,
        ON
    } scan_state_t;

endpackage

// File: rtl/display_scan_ctrl_if.sv
// Write/commit/scan-output bundle between a host and display_scan_ctrl.
interface display_scan_ctrl_if
    import display_pkg::*;
#(
    parameter int unsigned DIGITS = 4
);
    localparam int unsigned IDX_W = $clog2(DIGITS);

    logic                en;
    logic                wr_en;
    logic [IDX_W-1:0]    wr_addr;
    logic [CODE_W-1:0]   wr_data;
    logic                commit_req;
    logic                commit_ack;
    logic [CODE_W-1:0]   code;
    logic [DIGITS-1:0]   dig_en;
    logic                frame_done;

    modport master (
        output en, wr_en, wr_addr, wr_data, commit_req,
        input  commit_ack, code, dig_en, frame_done
    );

    modport slave (
        input  en, wr_en, wr_addr, wr_data, commit_req,
        output commit_ack, code, dig_en, frame_done
    );

endinterface

// File: rtl/display_scan_timer.sv
// Loadable phase down-counter; tc marks the last cycle of the current phase.
module display_scan_timer #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             tc
);

    logic [WIDTH-1:0] cnt;

    // Load on phase entry, then count down to zero; a dropped enable clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (!en) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign tc = (cnt == '0);

endmodule

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed digit scanner with a double-buffered code bank and
// frame-aligned atomic commit.
module display_scan_ctrl
    import display_pkg::*;
#(
    parameter int unsigned DIGITS = 4,
    parameter int unsigned DIV    = 1000,
    parameter int unsigned BLANK  = 16
) (
    input  logic              clk,
    input  logic              rst,
    display_scan_ctrl_if.slave bus
);

    localparam int unsigned IDX_W  = $clog2(DIGITS);
    localparam int unsigned MAX_PH = (DIV > BLANK) ? DIV : BLANK;
    localparam int unsigned CNT_W  = $clog2(MAX_PH + 1);

    localparam logic [CNT_W-1:0]  DIV_LD   = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0]  BLANK_LD = CNT_W'(BLANK - 1);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DIGITS - 1);
    localparam logic [IDX_W:0]    NUM_DIG  = (IDX_W + 1)'(DIGITS);
    localparam logic [DIGITS-1:0] ONE_HOT0 = DIGITS'(1);

    // The state enumerator BLANK is shadowed by the BLANK parameter, so state
    // names are always package-qualified here.
    scan_state_t       state;
    logic [IDX_W-1:0]  idx;
    logic [IDX_W-1:0]  idx_nxt;
    logic [CODE_W-1:0] shadow [DIGITS];
    logic [CODE_W-1:0] active [DIGITS];
    logic [CODE_W-1:0] code_q;
    logic [DIGITS-1:0] dig_en_q;
    logic              ack_q;
    logic              fd_q;
    logic              load;
    logic [CNT_W-1:0]  load_val;
    logic              tc;
    logic              frame_wrap;
    logic              commit;

    display_scan_timer #(
        .WIDTH (CNT_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .en       (bus.en),
        .load     (load),
        .load_val (load_val),
        .tc       (tc)
    );

    // Phase-length selection for the timer and frame/commit decisions.
    always_comb begin
        load       = 1'b0;
        load_val   = BLANK_LD;
        idx_nxt    = idx + 1'b1;
        frame_wrap = bus.en && (state == display_pkg::ON) && tc && (idx == LAST_IDX);
        // Idle commits right away; a running scan waits for the wrap edge.
        commit     = bus.commit_req && ((state == display_pkg::IDLE) || frame_wrap);
        if (bus.en) begin
            unique case (state)
                display_pkg::IDLE:  load = 1'b1;
                display_pkg::BLANK: begin
                    load     = tc;
                    load_val = DIV_LD;
                end
                display_pkg::ON:    load = tc;
                default:            load = 1'b0;
            endcase
        end
    end

    // Shadow writes land at any time; the active bank only changes on commit
    // and takes the pre-edge shadow contents.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DIGITS; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
        end else begin
            if (commit) begin
                active <= shadow;
            end
            if (bus.wr_en && ({1'b0, bus.wr_addr} < NUM_DIG)) begin
                shadow[bus.wr_addr] <= bus.wr_data;
            end
        end
    end

    // Scan FSM with registered code, digit enable and pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= display_pkg::IDLE;
            idx      <= '0;
            code_q   <= '0;
            dig_en_q <= '0;
            ack_q    <= 1'b0;
            fd_q     <= 1'b0;
        end else begin
            ack_q <= commit;
            fd_q  <= 1'b0;
            if (!bus.en) begin
                state    <= display_pkg::IDLE;
                idx      <= '0;
                code_q   <= '0;
                dig_en_q <= '0;
            end else begin
                unique case (state)
                    display_pkg::IDLE: begin
                        state  <= display_pkg::BLANK;
                        idx    <= '0;
                        code_q <= commit ? shadow[0] : active[0];
                    end
                    display_pkg::BLANK: begin
                        if (tc) begin
                            state    <= display_pkg::ON;
                            dig_en_q <= ONE_HOT0 << idx;
                        end
                    end
                    display_pkg::ON: begin
                        if (tc) begin
                            state    <= display_pkg::BLANK;
                            dig_en_q <= '0;
                            if (idx == LAST_IDX) begin
                                idx    <= '0;
                                fd_q   <= 1'b1;
                                // New frame shows freshly committed data at once.
                                code_q <= commit ? shadow[0] : active[0];
                            end else begin
                                idx    <= idx_nxt;
                                code_q <= active[idx_nxt];
                            end
                        end
                    end
                    default: state <= display_pkg::IDLE;
                endcase
            end
        end
    end

    assign bus.code       = code_q;
    assign bus.dig_en     = dig_en_q;
    assign bus.commit_ack = ack_q;
    assign bus.frame_done = fd_q;

endmodule
